// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers used by the arbiter and the bus controller.
package arb_pkg;

  localparam int ARB_NUM_MASTER = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector (highest set bit wins if several are set).
  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int k = 0; k < 32; k++) begin
      if (oh[k]) idx = k;
    end
    return idx;
  endfunction

  function automatic logic [31:0] idx_to_onehot(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/arb_onehot_lsb.sv
// Lowest-set-bit extraction with multi-hot detection for an incoming grant vector.
module arb_onehot_lsb
  import arb_pkg::*;
#(
  parameter int W = 4,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic          any_o,
  output logic          multi_o,
  output logic [IW-1:0] idx_o
);

  logic [W-1:0] lsbOnehot;
  logic [31:0]  lsbWide;
  int           lsbIdx;

  // Two's-complement trick isolates the lowest set bit; clearing it detects multi-hot.
  assign lsbOnehot = vec_i & (~vec_i + W'(1));
  assign any_o     = |vec_i;
  assign multi_o   = (vec_i & (vec_i - W'(1))) != '0;

  always_comb begin
    lsbWide = 32'(lsbOnehot);
    lsbIdx  = onehot_to_idx(lsbWide);
    idx_o   = IW'(lsbIdx);
  end

endmodule

// File: rtl/arb_bus_ctrl.sv
// Owns the shared slave channel for one granted burst and rotates arbiter priority round-robin.
module arb_bus_ctrl
  import arb_pkg::*;
#(
  parameter int NUM_MASTER = ARB_NUM_MASTER,
  parameter int DATA_W     = 32,
  parameter int MAX_BEATS  = 8,
  localparam int IW = $clog2(NUM_MASTER),
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTER-1:0]        grant_i,
  output logic [NUM_MASTER-1:0]        pri_o,
  input  logic [NUM_MASTER-1:0]        m_valid_i,
  input  logic [NUM_MASTER*DATA_W-1:0] m_data_i,
  input  logic [NUM_MASTER-1:0]        m_last_i,
  output logic [NUM_MASTER-1:0]        m_ready_o,
  output logic                         s_valid_o,
  output logic [DATA_W-1:0]            s_data_o,
  output logic                         s_last_o,
  input  logic                         s_ready_i,
  output logic [IW-1:0]                owner_o,
  output logic                         busy_o,
  output logic                         grant_err_o
);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTER-1:0] pri_q, pri_d;
  logic                  grant_err_q, grant_err_d;

  logic                  grantAny;
  logic                  grantMulti;
  logic [IW-1:0]         grantIdx;
  logic                  beat;
  int                    nextOwner;

  arb_onehot_lsb #(.W(NUM_MASTER)) u_lsb (
    .vec_i   (grant_i),
    .any_o   (grantAny),
    .multi_o (grantMulti),
    .idx_o   (grantIdx)
  );

  assign nextOwner = (int'(owner_q) + 1) % NUM_MASTER;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      pri_q       <= NUM_MASTER'(1);
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      pri_q       <= pri_d;
      grant_err_q <= grant_err_d;
    end
  end

  // Channel outputs are a zero-latency pass-through of the owner; everything idles outside OWN.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    pri_d       = pri_q;
    grant_err_d = 1'b0;
    s_valid_o   = 1'b0;
    s_data_o    = '0;
    s_last_o    = 1'b0;
    m_ready_o   = '0;
    beat        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grantAny) begin
          owner_d     = grantIdx;
          beat_cnt_d  = '0;
          grant_err_d = grantMulti;
          state_d     = OWN;
        end
      end
      OWN: begin
        s_valid_o          = m_valid_i[owner_q];
        s_data_o           = m_data_i[owner_q*DATA_W +: DATA_W];
        m_ready_o[owner_q] = s_ready_i;
        s_last_o           = s_valid_o &
                             (m_last_i[owner_q] | (beat_cnt_q == CW'(MAX_BEATS - 1)));
        beat               = s_valid_o & s_ready_i;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (s_last_o) begin
            // Counter parks at zero so it never exceeds the cap outside a burst.
            beat_cnt_d = '0;
            pri_d      = NUM_MASTER'(idx_to_onehot(nextOwner));
            state_d    = RELEASE;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pri_o       = pri_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q == OWN);
  assign grant_err_o = grant_err_q;

endmodule

// File: tb/tb_arb_bus_ctrl.sv
// Randomized scoreboard bench for arb_bus_ctrl with directed reset, wrap, cap and error cases.
module tb_arb_bus_ctrl;

  localparam int NM   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            owner;
  } beat_t;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     grant_i;
  logic [NM-1:0]     pri_o;
  logic [NM-1:0]     m_valid_i;
  logic [NM*DW-1:0]  m_data_i;
  logic [NM-1:0]     m_last_i;
  logic [NM-1:0]     m_ready_o;
  logic              s_valid_o;
  logic [DW-1:0]     s_data_o;
  logic              s_last_o;
  logic              s_ready_i;
  logic [1:0]        owner_o;
  logic              busy_o;
  logic              grant_err_o;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];
  int    expPriIdx = 0;

  arb_bus_ctrl #(.NUM_MASTER(NM), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
    .clk         (clk),
    .rst         (rst),
    .grant_i     (grant_i),
    .pri_o       (pri_o),
    .m_valid_i   (m_valid_i),
    .m_data_i    (m_data_i),
    .m_last_i    (m_last_i),
    .m_ready_o   (m_ready_o),
    .s_valid_o   (s_valid_o),
    .s_data_o    (s_data_o),
    .s_last_o    (s_last_o),
    .s_ready_i   (s_ready_i),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .grant_err_o (grant_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NM-1:0] priOf(input int idx);
    logic [NM-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int lowestBit(input logic [NM-1:0] g);
    for (int k = 0; k < NM; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Non-owner lanes carry junk so a wrong mux select shows up as a data miscompare.
  task automatic scrambleLanes();
    m_valid_i = NM'($urandom);
    m_data_i  = $urandom;
    m_last_i  = NM'($urandom);
  endtask

  // Monitor: every accepted slave beat must match the head of the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && s_valid_o && s_ready_i) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("s_data", 32'(s_data_o), 32'(e.data));
          checkOutput("s_last", 32'(s_last_o), 32'(e.last));
          checkOutput("owner_o", 32'(owner_o), 32'(e.owner));
          checkOutput("m_ready", 32'(m_ready_o), 32'(priOf(e.owner)));
        end
      end
    end
  end

  // One granted burst: called and returns at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [NM-1:0] grant, input int len,
                               input bit hasLast, input int readyPct);
    int            own, eff, idx, guard;
    bit            hs, multi;
    logic [DW-1:0] beats[$];
    beat_t         e;

    own   = lowestBit(grant);
    multi = $countones(grant) > 1;
    eff   = (hasLast && len < MAXB) ? len : MAXB;
    for (int k = 0; k < len; k++) beats.push_back(DW'($urandom));
    for (int k = 0; k < eff; k++) begin
      e.data  = beats[k];
      e.last  = (k == eff - 1);
      e.owner = own;
      sb.push_back(e);
    end

    scrambleLanes();
    grant_i = grant;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_on_grant", 32'(busy_o), 32'd1);
    checkOutput("owner_latched", 32'(owner_o), 32'(own));
    checkOutput("grant_err", 32'(grant_err_o), 32'(multi));
    checkOutput("pri_held", 32'(pri_o), 32'(priOf(expPriIdx)));

    idx   = 0;
    guard = 0;
    while (idx < eff && guard < 300) begin
      scrambleLanes();
      grant_i              = NM'($urandom_range(1, 15));
      m_valid_i[own]       = ($urandom_range(0, 99) < 80);
      m_data_i[own*DW+:DW] = beats[idx];
      m_last_i[own]        = hasLast && (idx == len - 1);
      s_ready_i            = ($urandom_range(0, 99) < readyPct);
      #1;
      hs = m_valid_i[own] && m_ready_o[own];
      @(posedge clk);
      if (hs) idx++;
      guard++;
      @(negedge clk);
      if (guard == 1) checkOutput("grant_err_pulse_end", 32'(grant_err_o), 32'd0);
    end
    if (idx < eff) checkOutput("burst_timeout", 32'(idx), 32'(eff));

    expPriIdx = (own + 1) % NM;
    scrambleLanes();
    checkOutput("busy_release", 32'(busy_o), 32'd0);
    checkOutput("s_valid_release", 32'(s_valid_o), 32'd0);
    checkOutput("pri_rotated", 32'(pri_o), 32'(priOf(expPriIdx)));
    @(posedge clk);
    @(negedge clk);
    grant_i = '0;
    checkOutput("release_ignores_grant", 32'(busy_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_no_grant", 32'(busy_o), 32'd0);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    expPriIdx = 0;
    sb.delete();
    checkOutput("rst_pri", 32'(pri_o), 32'(priOf(0)));
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_s_valid", 32'(s_valid_o), 32'd0);
    checkOutput("rst_m_ready", 32'(m_ready_o), 32'd0);
    checkOutput("rst_owner", 32'(owner_o), 32'd0);
  endtask

  // Multi-hot grant, one beat, then reset while the owner still holds valid.
  task automatic applyResetMidBurst();
    beat_t e;
    grant_i   = 4'b0110;
    m_valid_i = '0;
    s_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("multi_owner", 32'(owner_o), 32'd1);
    checkOutput("multi_err", 32'(grant_err_o), 32'd1);
    grant_i          = '0;
    e.data           = 8'h5C;
    e.last           = 1'b0;
    e.owner          = 1;
    sb.push_back(e);
    m_valid_i        = 4'b0010;
    m_data_i[15:8]   = 8'h5C;
    m_last_i         = '0;
    s_ready_i        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("multi_err_once", 32'(grant_err_o), 32'd0);
    s_ready_i = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_ready_i = 1'b1;
    checkOutput("midrst_s_valid", 32'(s_valid_o), 32'd0);
    checkOutput("midrst_m_ready", 32'(m_ready_o), 32'd0);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    rst       = 1'b0;
    m_valid_i = '0;
    expPriIdx = 0;
    checkOutput("midrst_pri", 32'(pri_o), 32'(priOf(0)));
  endtask

  initial begin
    logic [NM-1:0] g;
    int            len;
    bit            hl;
    rst       = 1'b1;
    grant_i   = '0;
    m_valid_i = '0;
    m_data_i  = '0;
    m_last_i  = '0;
    s_ready_i = 1'b0;
    @(negedge clk);
    applyReset(2);

    applyStimulus(4'b0100, 2, 1'b1, 100);
    applyStimulus(4'b0010, 6, 1'b0, 100);
    applyStimulus(4'b1000, 3, 1'b1, 100);
    applyStimulus(4'b0001, 4, 1'b1, 50);
    applyResetMidBurst();
    checkOutput("sb_flushed_by_reset", 32'(sb.size()), 32'd0);

    for (int n = 0; n < 40; n++) begin
      g   = NM'($urandom_range(1, 15));
      hl  = $urandom_range(0, 1) == 1;
      len = hl ? $urandom_range(1, 7) : $urandom_range(MAXB, 7);
      applyStimulus(g, len, hl, $urandom_range(40, 100));
    end

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
